apu_length_bank: RTL and testbench

Parametrised bank of NUM_CH APU length counters sharing one 32-entry length lookup table. It replaces the per-channel single length counter with hardware-accurate load/clock collision handling, a delayed-halt latch, per-channel enable gating and a count readback. It sits in the APU between the register-write decoder ($4000–$400F and $4015 writes) and the channel outputs. The frame sequencer provides its half-frame strobe, and $4015 reads take channel status from it.

---
 rtl/apu_pkg.sv | 48 ++++
 rtl/apu_length_slot.sv | 53 +++++
 rtl/apu_length_bank.sv | 44 ++++
 tb/tb_apu_length_bank.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared APU definitions: length table lookup and index width.
package apu_pkg;

    localparam int LEN_IDX_W = 5;

    // Standard NES length counter load table
    function automatic logic [7:0] length_lookup(logic [4:0] idx);
        logic [7:0] v;
        v = 8'd0;
        case (idx)
            5'h00: v = 8'd10;
            5'h01: v = 8'd254;
            5'h02: v = 8'd20;
            5'h03: v = 8'd2;
            5'h04: v = 8'd40;
            5'h05: v = 8'd4;
            5'h06: v = 8'd80;
            5'h07: v = 8'd6;
            5'h08: v = 8'd160;
            5'h09: v = 8'd8;
            5'h0A: v = 8'd60;
            5'h0B: v = 8'd10;
            5'h0C: v = 8'd14;
            5'h0D: v = 8'd12;
            5'h0E: v = 8'd26;
            5'h0F: v = 8'd14;
            5'h10: v = 8'd12;
            5'h11: v = 8'd16;
            5'h12: v = 8'd24;
            5'h13: v = 8'd18;
            5'h14: v = 8'd48;
            5'h15: v = 8'd20;
            5'h16: v = 8'd96;
            5'h17: v = 8'd22;
            5'h18: v = 8'd192;
            5'h19: v = 8'd24;
            5'h1A: v = 8'd72;
            5'h1B: v = 8'd26;
            5'h1C: v = 8'd16;
            5'h1D: v = 8'd28;
            5'h1E: v = 8'd32;
            5'h1F: v = 8'd30;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/apu_length_slot.sv
// One APU length counter with load/half-clock collision rules
// and a one-cycle delayed halt flag.
module apu_length_slot
    import apu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_clk_en_i,
    input  logic             half_clk_en_i,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             halt_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             halt_q, halt_d;
    logic             is_zero;

    assign is_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        halt_d  = halt_q;
        if (cpu_clk_en_i) begin
            halt_d = halt_i;
            if (!enable_i) begin
                count_d = '0;
            end else if (load_i && (!half_clk_en_i || is_zero)) begin
                count_d = load_val_i;
            end else if (half_clk_en_i && !halt_q && !is_zero) begin
                // Decision uses the previously sampled halt
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            halt_q  <= halt_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/apu_length_bank.sv
// Bank of NUM_CH length counters sharing one length lookup table.
module apu_length_bank
    import apu_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_clk_en,
    input  logic                      half_clk_en,
    input  logic [NUM_CH-1:0]         enable,
    input  logic [NUM_CH-1:0]         load,
    input  logic [NUM_CH*LEN_IDX_W-1:0] load_idx,
    input  logic [NUM_CH-1:0]         halt,
    output logic [NUM_CH-1:0]         non_zero,
    output logic [NUM_CH*CNT_W-1:0]   count
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] val;
        logic [CNT_W-1:0] cnt;

        assign val = CNT_W'(length_lookup(load_idx[i*LEN_IDX_W +: LEN_IDX_W]));

        apu_length_slot #(
            .CNT_W(CNT_W)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .cpu_clk_en_i (cpu_clk_en),
            .half_clk_en_i(half_clk_en),
            .enable_i     (enable[i]),
            .load_i       (load[i]),
            .load_val_i   (val),
            .halt_i       (halt[i]),
            .count_o      (cnt)
        );

        assign count[i*CNT_W +: CNT_W] = cnt;
        assign non_zero[i]             = |cnt;
    end

endmodule

// File: tb/tb_apu_length_bank.sv
// Directed + random check of apu_length_bank against a behavioural model.
module tb_apu_length_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_clk_en;
    logic        half_clk_en;
    logic [3:0]  enable;
    logic [3:0]  load;
    logic [19:0] load_idx;
    logic [3:0]  halt;
    logic [3:0]  non_zero;
    logic [31:0] count;

    int total = 0;
    int bad   = 0;

    int tbl [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                     12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
    int mcnt [4];
    bit mhalt [4];
    int saved [4];

    always #5 clk = ~clk;

    apu_length_bank #(.NUM_CH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_clk_en (cpu_clk_en),
        .half_clk_en(half_clk_en),
        .enable     (enable),
        .load       (load),
        .load_idx   (load_idx),
        .halt       (halt),
        .non_zero   (non_zero),
        .count      (count)
    );

    function automatic logic [31:0] get(int ch);
        return {24'd0, count[ch*8 +: 8]};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_idx(int ch, int idx);
        load_idx[ch*5 +: 5] = 5'(idx);
    endtask

    // Model: reference behaviour evaluated at each rising edge
    task automatic model_edge();
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                mcnt[c]  = 0;
                mhalt[c] = 0;
            end
        end else if (cpu_clk_en) begin
            for (int c = 0; c < 4; c++) begin
                int idx;
                idx = int'(load_idx[c*5 +: 5]);
                if (!enable[c])
                    mcnt[c] = 0;
                else if (load[c] && (!half_clk_en || mcnt[c] == 0))
                    mcnt[c] = tbl[idx];
                else if (half_clk_en && !mhalt[c] && mcnt[c] > 0)
                    mcnt[c] = mcnt[c] - 1;
                mhalt[c] = halt[c];
            end
        end
    endtask

    task automatic tick();
        logic [3:0] enz;
        @(posedge clk);
        model_edge();
        #1;
        enz = '0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("model_cnt%0d", c), get(c), 32'(mcnt[c]));
            enz[c] = (mcnt[c] != 0);
        end
        chk("model_nz", {28'd0, non_zero}, {28'd0, enz});
    endtask

    initial begin
        rst = 1'b1;
        cpu_clk_en = 1'b1;
        half_clk_en = 1'b0;
        enable = '0;
        load = '0;
        load_idx = '0;
        halt = '0;
        #1;
        tick();
        tick();
        chk("reset_cnt", {24'd0, count[7:0]} | get(1) | get(2) | get(3), 32'd0);
        chk("reset_nz", {28'd0, non_zero}, 32'd0);
        rst = 1'b0;

        // Load 254 on channel 0
        enable = 4'hF;
        load = 4'b0001;
        set_idx(0, 1);
        tick();
        chk("load254", get(0), 32'd254);
        chk("load254_nz", {28'd0, non_zero}, 32'd1);
        load = '0;

        // Decrement to zero and stick
        load = 4'b0010;
        set_idx(1, 3);
        tick();
        chk("dec_load", get(1), 32'd2);
        load = '0;
        half_clk_en = 1'b1;
        tick();
        chk("dec_1", get(1), 32'd1);
        tick();
        chk("dec_0", get(1), 32'd0);
        chk("dec_nz", {31'd0, non_zero[1]}, 32'd0);
        tick();
        chk("dec_stick", get(1), 32'd0);
        half_clk_en = 1'b0;

        // Collision of load and half clock
        load = 4'b0100;
        set_idx(2, 0);
        tick();
        chk("col_pre", get(2), 32'd10);
        set_idx(2, 4);
        half_clk_en = 1'b1;
        tick();
        chk("col_disc", get(2), 32'd9);
        load = '0;
        half_clk_en = 1'b0;
        enable = 4'b1011;
        tick();
        enable = 4'hF;
        tick();
        load = 4'b0100;
        half_clk_en = 1'b1;
        tick();
        chk("col_zero", get(2), 32'd40);
        load = '0;
        half_clk_en = 1'b0;

        // Delayed halt
        load = 4'b1000;
        set_idx(3, 2);
        tick();
        load = '0;
        half_clk_en = 1'b1;
        halt[3] = 1'b1;
        tick();
        chk("halt_same", get(3), 32'd19);
        tick();
        chk("halt_hold", get(3), 32'd19);
        half_clk_en = 1'b0;
        halt[3] = 1'b0;
        tick();
        half_clk_en = 1'b1;
        tick();
        chk("halt_clr", get(3), 32'd18);
        half_clk_en = 1'b0;

        // Enable gating
        load = 4'b0001;
        set_idx(0, 5'h16);
        tick();
        chk("en_pre", get(0), 32'd96);
        load = '0;
        enable[0] = 1'b0;
        tick();
        chk("en_off", get(0), 32'd0);
        load = 4'b0001;
        set_idx(0, 1);
        tick();
        chk("en_load_off", get(0), 32'd0);
        load = '0;
        enable[0] = 1'b1;
        tick();
        load = 4'b0001;
        set_idx(0, 5'h1F);
        tick();
        chk("en_reload", get(0), 32'd30);
        load = '0;

        // Nothing moves without cpu_clk_en
        for (int c = 0; c < 4; c++) saved[c] = int'(get(c));
        cpu_clk_en = 1'b0;
        load = 4'hF;
        half_clk_en = 1'b1;
        halt = 4'hF;
        enable = 4'h0;
        load_idx = 20'hFFFFF;
        tick();
        tick();
        for (int c = 0; c < 4; c++)
            chk($sformatf("ce_hold%0d", c), get(c), 32'(saved[c]));
        rst = 1'b1;
        tick();
        chk("ce_rst", count, 32'd0);
        chk("ce_rst_nz", {28'd0, non_zero}, 32'd0);
        rst = 1'b0;
        cpu_clk_en = 1'b1;
        load = '0;
        half_clk_en = 1'b0;
        halt = '0;
        enable = 4'hF;

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            cpu_clk_en  = ($urandom_range(0, 3) != 0);
            half_clk_en = ($urandom_range(0, 4) == 0);
            for (int c = 0; c < 4; c++) begin
                enable[c] = ($urandom_range(0, 19) != 0);
                load[c]   = ($urandom_range(0, 6) == 0);
                if ($urandom_range(0, 7) == 0) halt[c] = ~halt[c];
            end
            load_idx = 20'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
